// File: rtl/fir_mac_engine.sv
// rtl/fir_mac_engine.sv - streaming single-MAC FIR engine with rounding and saturation
module fir_mac_engine #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 16,
  parameter int MAX_TAPS = 32,
  parameter int OUT_W    = 21,
  parameter int ACC_W    = DATA_W + COEF_W + $clog2(MAX_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(MAX_TAPS):0]     cfg_taps,
  input  logic [5:0]                    cfg_shift,
  input  logic                          coef_wr,
  input  logic [$clog2(MAX_TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]      coef_data,
  input  logic                          hist_clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_W-1:0]      in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_W-1:0]       out_data,
  output logic                          out_sat,
  output logic                          busy
);

  localparam int AW = $clog2(MAX_TAPS);
  localparam int TW = AW + 1;
  localparam int PW = DATA_W + COEF_W;
  // One guard bit so adding the rounding constant can never wrap
  localparam int SW = ACC_W + 1;
  localparam logic signed [SW-1:0] SAT_MAX = {{(SW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN = {{(SW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  state_t state_q, state_d;

  logic [TW-1:0]            taps_q, taps_d, k_q, k_d, taps_clamp;
  logic [5:0]               shift_q, shift_d;
  logic signed [DATA_W-1:0] x_q [MAX_TAPS];
  logic signed [DATA_W-1:0] x_d [MAX_TAPS];
  logic signed [COEF_W-1:0] c_q [MAX_TAPS];
  logic signed [COEF_W-1:0] c_d [MAX_TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d, p_ext, acc_fin;
  logic signed [PW-1:0]     p_q, p_d, prod;
  logic signed [SW-1:0]     rnd, sum_r, res;
  logic signed [OUT_W-1:0]  out_data_q, out_data_d;
  logic                     out_sat_q, out_sat_d;
  logic                     accept, mac_last;
  logic [AW-1:0]            k_idx;

  // Handshake qualifiers and runtime tap-count clamping
  always_comb begin
    accept   = (state_q == S_IDLE) && in_valid && !hist_clr;
    mac_last = (state_q == S_MAC) && (k_q == taps_q);
    k_idx    = k_q[AW-1:0];
    if (cfg_taps == '0)                 taps_clamp = TW'(1);
    else if (cfg_taps > TW'(MAX_TAPS))  taps_clamp = TW'(MAX_TAPS);
    else                                taps_clamp = cfg_taps;
  end

  // Arithmetic: registered product feeds the accumulator one cycle later, so the
  // final cycle folds in the last product and then rounds, shifts and saturates
  always_comb begin
    prod    = PW'(c_q[k_idx]) * PW'(x_q[k_idx]);
    p_ext   = ACC_W'(p_q);
    acc_fin = acc_q + p_ext;
    rnd     = (shift_q == 6'd0) ? '0 : (SW'(1) << (shift_q - 6'd1));
    sum_r   = SW'(acc_fin) + rnd;
    res     = sum_r >>> shift_q;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)    state_d = S_MAC;
      S_MAC:   if (mac_last)  state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == S_IDLE) && !hist_clr;
    out_valid = (state_q == S_OUT);
    busy      = (state_q != S_IDLE);
    out_data  = out_data_q;
    out_sat   = out_sat_q;
  end

  // Datapath next-state: delay line, coefficient file, MAC and result capture
  always_comb begin
    x_d        = x_q;
    c_d        = c_q;
    acc_d      = acc_q;
    p_d        = p_q;
    k_d        = k_q;
    taps_d     = taps_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    case (state_q)
      S_IDLE: begin
        if (hist_clr) begin
          for (int i = 0; i < MAX_TAPS; i++) x_d[i] = '0;
        end else if (in_valid) begin
          x_d[0] = in_data;
          for (int i = 1; i < MAX_TAPS; i++) x_d[i] = x_q[i-1];
          taps_d  = taps_clamp;
          shift_d = cfg_shift;
          acc_d   = '0;
          p_d     = '0;
          k_d     = '0;
        end
        if (coef_wr && !accept) c_d[coef_addr] = coef_data;
      end
      S_MAC: begin
        if (mac_last) begin
          if (res > SAT_MAX) begin
            out_data_d = SAT_MAX[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end else if (res < SAT_MIN) begin
            out_data_d = SAT_MIN[OUT_W-1:0];
            out_sat_d  = 1'b1;
          end else begin
            out_data_d = res[OUT_W-1:0];
            out_sat_d  = 1'b0;
          end
        end else begin
          acc_d = acc_fin;
          p_d   = prod;
          k_d   = k_q + TW'(1);
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_TAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
      acc_q      <= '0;
      p_q        <= '0;
      k_q        <= '0;
      taps_q     <= TW'(1);
      shift_q    <= '0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
    end else begin
      x_q        <= x_d;
      c_q        <= c_d;
      acc_q      <= acc_d;
      p_q        <= p_d;
      k_q        <= k_d;
      taps_q     <= taps_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
    end
  end

endmodule
